sync_sig_multi: RTL and testbench

//  Parametrised multi-channel successor to the single-bit FF synchronizers.

---
 rtl/sync_sig_multi_pkg.sv | 16 +
 rtl/sync_sig_multi_chan.sv | 90 +++++++++
 rtl/sync_sig_multi.sv | 39 +++
 tb/tb_sync_sig_multi.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sync_sig_multi_pkg.sv
// Shared constants for the multi-channel synchronizer: edge-mode encodings and chain-depth limits.
package sync_sig_multi_pkg;

    localparam logic [1:0] SYNC_MODE_LEVEL = 2'd0;
    localparam logic [1:0] SYNC_MODE_RISE  = 2'd1;
    localparam logic [1:0] SYNC_MODE_FALL  = 2'd2;
    localparam logic [1:0] SYNC_MODE_ANY   = 2'd3;

    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;

    function automatic bit stages_ok(input int unsigned stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/sync_sig_multi_chan.sv
// One synchronizer channel: FF chain, optional glitch filter, edge detect and pulse/hold stage.
module sync_chan
    import sync_sig_multi_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter logic        INIT   = 1'b0,
    parameter int unsigned FILT   = 0,
    parameter logic [1:0]  MODE   = SYNC_MODE_LEVEL,
    parameter logic        HOLD   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    input  logic ack,
    output logic out,
    output logic pulse,
    output logic overflow
);

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("sync_chan: STAGES must be within 2..4");
    end

    (* shreg_extract = "no" *) logic [STAGES-1:0] ff;
    logic sync;
    logic prev;
    logic ev;

    always_ff @(posedge clk) begin
        if (!rst_n) ff <= {STAGES{INIT}};
        else        ff <= {ff[STAGES-2:0], sig};
    end

    assign sync = ff[STAGES-1];

    // A mismatch must persist FILT consecutive cycles before it reaches out.
    if (FILT == 0) begin : g_no_filt
        assign out = sync;
    end else begin : g_filt
        localparam int unsigned CW = $clog2(FILT + 1);
        logic [CW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out <= INIT;
                cnt <= '0;
            end else if (sync == out) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                out <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= INIT;
        else        prev <= out;
    end

    always_comb begin
        ev = 1'b0;
        case (MODE)
            SYNC_MODE_RISE: ev = out & ~prev;
            SYNC_MODE_FALL: ev = ~out & prev;
            SYNC_MODE_ANY:  ev = out ^ prev;
            default:        ev = 1'b0;
        endcase
    end

    // Held pulses stay up until acked; a new event landing on a pending pulse without ack is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse    <= 1'b0;
            overflow <= 1'b0;
        end else if (!HOLD) begin
            pulse    <= ev;
            overflow <= 1'b0;
        end else if (ev && !pulse) begin
            pulse <= 1'b1;
        end else if (pulse && ack && !ev) begin
            pulse <= 1'b0;
        end else if (pulse && ev && !ack) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/sync_sig_multi.sv
// WIDTH independent single-bit synchronizers; no cross-channel coherency, so never feed a multi-bit bus through it.
module sync_sig_multi
    import sync_sig_multi_pkg::*;
#(
    parameter int unsigned          WIDTH  = 8,
    parameter int unsigned          STAGES = 2,
    parameter logic [WIDTH-1:0]     INIT   = '0,
    parameter int unsigned          FILT   = 0,
    parameter logic [2*WIDTH-1:0]   MODE   = '0,
    parameter logic [WIDTH-1:0]     HOLD   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pulse,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] overflow
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_chan #(
            .STAGES (STAGES),
            .INIT   (INIT[i]),
            .FILT   (FILT),
            .MODE   (MODE[2*i +: 2]),
            .HOLD   (HOLD[i])
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig      (sig[i]),
            .ack      (ack[i]),
            .out      (out[i]),
            .pulse    (pulse[i]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_sync_sig_multi.sv
// Directed bench: an unfiltered 4-channel instance driven from a cycle table, and a filtered one for multi-cycle corners.
module tb_sync_sig_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig_a, ack_a, out_a, pulse_a, ovf_a;
    logic [3:0] sig_b, ack_b, out_b, pulse_b, ovf_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ch0 level, ch1 rise, ch2 any edge, ch3 rise with hold
    sync_sig_multi #(
        .WIDTH(4), .STAGES(2), .INIT(4'b0000), .FILT(0),
        .MODE(8'b01_11_01_00), .HOLD(4'b1000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sig(sig_a), .out(out_a),
        .pulse(pulse_a), .ack(ack_a), .overflow(ovf_a)
    );

    // all channels rise mode, ch0 held, filtered, non-zero init
    sync_sig_multi #(
        .WIDTH(4), .STAGES(3), .INIT(4'b1010), .FILT(4),
        .MODE(8'b01_01_01_01), .HOLD(4'b0001)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sig(sig_b), .out(out_b),
        .pulse(pulse_b), .ack(ack_b), .overflow(ovf_b)
    );

    typedef struct {
        logic [3:0] sig;
        logic [3:0] ack;
        logic [3:0] out;
        logic [3:0] pulse;
        logic [3:0] ovf;
    } vec_t;

    vec_t tbl[31];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int rise_at;
        int fall_at;

        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0111, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0111, 4'b0000, 4'b0111, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0011, 4'b0000, 4'b0111, 4'b0110, 4'b0000};
        tbl[6]  = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0011, 4'b0000, 4'b0011, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0001, 4'b0000, 4'b1001, 4'b1000, 4'b0000};
        tbl[14] = '{4'b0001, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[15] = '{4'b1001, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[16] = '{4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b0000};
        tbl[17] = '{4'b1001, 4'b1000, 4'b1001, 4'b1000, 4'b0000};
        tbl[18] = '{4'b1001, 4'b1000, 4'b1001, 4'b0000, 4'b0000};
        tbl[19] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        tbl[20] = '{4'b0001, 4'b1000, 4'b1001, 4'b0000, 4'b0000};
        tbl[21] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[22] = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[23] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        tbl[24] = '{4'b0001, 4'b0000, 4'b1001, 4'b1000, 4'b0000};
        tbl[25] = '{4'b0001, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[26] = '{4'b1001, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        tbl[27] = '{4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b0000};
        tbl[28] = '{4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b1000};
        tbl[29] = '{4'b1001, 4'b1000, 4'b1001, 4'b0000, 4'b1000};
        tbl[30] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b1000};

        rst_n = 1'b0;
        sig_a = 4'b0000;
        ack_a = 4'b0000;
        sig_b = 4'b1010;
        ack_b = 4'b0000;
        step();
        step();
        chk("rst_a_out",   32'(out_a),   32'h0);
        chk("rst_a_pulse", 32'(pulse_a), 32'h0);
        chk("rst_a_ovf",   32'(ovf_a),   32'h0);
        chk("rst_b_out",   32'(out_b),   32'ha);
        chk("rst_b_pulse", 32'(pulse_b), 32'h0);
        chk("rst_b_ovf",   32'(ovf_b),   32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            sig_a = tbl[i].sig;
            ack_a = tbl[i].ack;
            step();
            chk($sformatf("tbl%0d_out", i),   32'(out_a),   32'(tbl[i].out));
            chk($sformatf("tbl%0d_pulse", i), 32'(pulse_a), 32'(tbl[i].pulse));
            chk($sformatf("tbl%0d_ovf", i),   32'(ovf_a),   32'(tbl[i].ovf));
        end
        ack_a = 4'b0000;

        // 3-cycle glitch on ch0 must be swallowed by the filter
        sig_b = 4'b1011;
        for (int k = 0; k < 3; k++) step();
        sig_b = 4'b1010;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("glitch_out", 32'(out_b), 32'ha);
        end

        // 6-cycle high: out follows STAGES+FILT cycles after each edge
        rise_at = 0;
        fall_at = 0;
        sig_b = 4'b1011;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 6) sig_b = 4'b1010;
            if (rise_at == 0 && out_b[0]) rise_at = k;
            if (rise_at != 0 && fall_at == 0 && !out_b[0]) fall_at = k;
        end
        chk("filt_rise_lat", 32'(rise_at), 32'd7);
        chk("filt_fall_lat", 32'(fall_at - 6), 32'd7);
        chk("held_pulse",    32'(pulse_b), 32'h1);
        chk("held_no_ovf",   32'(ovf_b),   32'h0);

        // second rise with pulse still pending and no ack
        sig_b = 4'b1011;
        for (int k = 0; k < 10; k++) step();
        chk("ovf_out",   32'(out_b),   32'hb);
        chk("ovf_pulse", 32'(pulse_b), 32'h1);
        chk("ovf_set",   32'(ovf_b),   32'h1);

        // one-cycle reset mid-activity with sig back at INIT
        sig_b = 4'b1010;
        rst_n = 1'b0;
        step();
        chk("mid_rst_out",   32'(out_b),   32'ha);
        chk("mid_rst_pulse", 32'(pulse_b), 32'h0);
        chk("mid_rst_ovf",   32'(ovf_b),   32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_pulse", 32'(pulse_b), 32'h0);
            chk("post_rst_out",   32'(out_b),   32'ha);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
